// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Contents:
//   scan_state_e - scan FSM states (blanking dead time, digit shown)
//   SEG_OFF      - active-low segment pattern with every segment dark
//   SEG_CODE     - active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
package display_pkg;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] SEG_CODE [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/display_scan_controller_if.sv
// Bundle between a value source and the scan controller.
// Ports:
//   valor_i   - packed hex nibbles, nibble k drives digit k
//   mascara_i - per-digit enable (0 = digit dark, slot still consumed)
//   punto_i   - per-digit decimal point request (1 = lit)
//   an_o      - active-low anode selects
//   seg_o     - active-low segments {g,f,e,d,c,b,a}
//   dp_o      - active-low decimal point
//   digito_o  - index of the digit currently owning the bus
// master drives the values, slave is the controller.
interface display_scan_controller_if #(
  parameter int N_DIGITS = 4
);
  localparam int IW = $clog2(N_DIGITS);

  logic [4*N_DIGITS-1:0] valor_i;
  logic [N_DIGITS-1:0]   mascara_i;
  logic [N_DIGITS-1:0]   punto_i;
  logic [N_DIGITS-1:0]   an_o;
  logic [6:0]            seg_o;
  logic                  dp_o;
  logic [IW-1:0]         digito_o;

  modport master (
    output valor_i, mascara_i, punto_i,
    input  an_o, seg_o, dp_o, digito_o
  );

  modport slave (
    input  valor_i, mascara_i, punto_i,
    output an_o, seg_o, dp_o, digito_o
  );

endinterface

// File: rtl/hex_to_7seg.sv
// Combinational hex-to-seven-segment decoder.
// Ports:
//   hex_i - 4-bit value 0..F
//   seg_o - active-low segments {g,f,e,d,c,b,a}
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_CODE[hex_i];
  end

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexes N_DIGITS seven-segment digits over one shared bus.
// A free-running prescaler sets the slot length; each slot starts with
// BLANK_CYCLES of dead time (all dark) before the digit is driven, which
// keeps the previous digit's segments from ghosting onto the next anode.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - slave side of display_scan_controller_if (values in, pins out)
// All pin outputs are registered one clk after the state/index change.
module display_scan_controller #(
  parameter int N_DIGITS     = 4,
  parameter int TICK_COUNT   = 9999,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  display_scan_controller_if.slave   bus
);
  import display_pkg::*;

  localparam int PW = $clog2(TICK_COUNT + 1);
  localparam int BW = $clog2(BLANK_CYCLES + 1);
  localparam int IW = $clog2(N_DIGITS);

  logic [PW-1:0]       presc_q, presc_d;
  logic [BW-1:0]       blank_q, blank_d;
  logic [IW-1:0]       idx_q, idx_d;
  scan_state_e         state_q, state_d;
  logic [3:0]          nib_q, nib_d;
  logic                pt_q, pt_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [IW-1:0]       digito_q, digito_d;
  logic                tick;
  logic [6:0]          seg_dec;

  hex_to_7seg u_dec (
    .hex_i (nib_q),
    .seg_o (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q  <= '0;
      blank_q  <= '0;
      idx_q    <= '0;
      state_q  <= S_BLANK;
      an_q     <= '1;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
      digito_q <= '0;
    end else begin
      presc_q  <= presc_d;
      blank_q  <= blank_d;
      idx_q    <= idx_d;
      state_q  <= state_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      digito_q <= digito_d;
    end
  end

  // Latched digit data is only observed in S_SHOW, which is always entered
  // through a latch, so it needs no reset.
  always_ff @(posedge clk) begin
    nib_q <= nib_d;
    pt_q  <= pt_d;
  end

  always_comb begin
    tick    = (presc_q == PW'(TICK_COUNT));
    presc_d = tick ? '0 : presc_q + 1'b1;

    blank_d = blank_q;
    idx_d   = idx_q;
    state_d = state_q;
    nib_d   = nib_q;
    pt_d    = pt_q;

    case (state_q)
      S_BLANK: begin
        // A tick landing here is ignored: the index only advances from S_SHOW.
        if (blank_q == BW'(BLANK_CYCLES - 1)) begin
          blank_d = '0;
          nib_d   = bus.valor_i[4*int'(idx_q) +: 4];
          pt_d    = bus.punto_i[idx_q];
          state_d = S_SHOW;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      S_SHOW: begin
        if (tick) begin
          idx_d   = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
          state_d = S_BLANK;
        end
      end
      default: state_d = S_BLANK;
    endcase

    an_d     = '1;
    seg_d    = SEG_OFF;
    dp_d     = 1'b1;
    digito_d = idx_q;
    if (state_q == S_SHOW) begin
      // Mask is applied live so a digit can be darkened mid-slot.
      an_d[idx_q] = ~bus.mascara_i[idx_q];
      seg_d       = seg_dec;
      dp_d        = ~pt_q;
    end
  end

  assign bus.an_o     = an_q;
  assign bus.seg_o    = seg_q;
  assign bus.dp_o     = dp_q;
  assign bus.digito_o = digito_q;

endmodule

// File: tb/tb_display_scan_controller.sv
module tb_display_scan_controller;

  localparam int ND = 4;
  localparam int TC = 9;
  localparam int BC = 2;
  localparam int SLOT = TC + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  display_scan_controller_if #(.N_DIGITS(ND)) bus ();

  display_scan_controller #(
    .N_DIGITS     (ND),
    .TICK_COUNT   (TC),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] dig;
  } exp_t;

  exp_t sb[$];

  logic [6:0] dec_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [3:0] prev_an = 4'hF;
  int hi_run = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_blank(input string tag, input logic [1:0] dig);
    chk({tag, "_an"},  16'(bus.an_o),     16'hF);
    chk({tag, "_seg"}, 16'(bus.seg_o),    16'h7F);
    chk({tag, "_dp"},  16'(bus.dp_o),     16'h1);
    chk({tag, "_dig"}, 16'(bus.digito_o), 16'(dig));
  endtask

  // One full slot of digit d: expectation pushed from the inputs present
  // before the slot, optionally changing valor_i halfway through the show.
  task automatic run_slot(input int d, input bit mid_chg, input logic [15:0] mid_val);
    exp_t e;
    logic [15:0] v;
    v = bus.valor_i;
    e.an  = bus.mascara_i[d] ? ~(4'b0001 << d) : 4'hF;
    e.seg = dec_tab[v[4*d +: 4]];
    e.dp  = ~bus.punto_i[d];
    e.dig = 2'(d);
    sb.push_back(e);
    for (int i = 0; i < SLOT; i++) begin
      if (mid_chg && i == 5) bus.valor_i = mid_val;
      step();
      if (i < BC) begin
        chk_blank($sformatf("blank_d%0d", d), 2'(d));
      end else begin
        chk($sformatf("an_d%0d", d),  16'(bus.an_o),     16'(sb[0].an));
        chk($sformatf("seg_d%0d", d), 16'(bus.seg_o),    16'(sb[0].seg));
        chk($sformatf("dp_d%0d", d),  16'(bus.dp_o),     16'(sb[0].dp));
        chk($sformatf("dig_d%0d", d), 16'(bus.digito_o), 16'(sb[0].dig));
      end
    end
    void'(sb.pop_front());
  endtask

  // Anode-safety monitor: never more than one anode low, and any anode
  // turning on is preceded by at least two all-dark cycles.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      assert ($countones(~bus.an_o) <= 1) else begin
        errors++;
        $error("FAIL onehot: observed an %b expected at most one low", bus.an_o);
      end
      if (bus.an_o != 4'hF) begin
        checks++;
        if (prev_an == 4'hF) begin
          assert (hi_run >= 2) else begin
            errors++;
            $error("FAIL deadtime: observed %0d dark cycles expected >= 2", hi_run);
          end
        end else begin
          assert (bus.an_o === prev_an) else begin
            errors++;
            $error("FAIL switch: observed an %b after %b expected dark gap", bus.an_o, prev_an);
          end
        end
        hi_run = 0;
      end else begin
        hi_run++;
      end
      prev_an = bus.an_o;
    end
  end

  initial begin
    bus.valor_i   = 16'h4321;
    bus.mascara_i = 4'hF;
    bus.punto_i   = 4'h0;
    rst_n = 1'b0;

    // Reset hold
    for (int i = 0; i < 3; i++) begin
      step();
      chk_blank("reset", 2'd0);
    end
    mon_en = 1'b1;
    rst_n = 1'b1;

    // 4321 across digits 0..3 and wrap to digit 0, then rest of scan 2
    for (int k = 0; k < 8; k++) run_slot(k % ND, 1'b0, 16'h0);

    // Mid-slot change of valor_i during digit 0
    bus.valor_i = 16'h0000;
    run_slot(0, 1'b1, 16'hFFFF);
    for (int k = 1; k < ND; k++) run_slot(k, 1'b0, 16'h0);

    // Masked digits and decimal points
    bus.valor_i   = 16'h4321;
    bus.mascara_i = 4'b1010;
    bus.punto_i   = 4'b0010;
    for (int k = 0; k < ND; k++) run_slot(k, 1'b0, 16'h0);

    // Reset pulse during digit 2 show
    bus.mascara_i = 4'hF;
    bus.punto_i   = 4'h0;
    bus.valor_i   = 16'hA5C7;
    run_slot(0, 1'b0, 16'h0);
    run_slot(1, 1'b0, 16'h0);
    for (int i = 0; i < 5; i++) step();
    chk("mid_show_an", 16'(bus.an_o), 16'hB);
    rst_n = 1'b0;
    step();
    chk_blank("pulse_rst", 2'd0);
    rst_n = 1'b1;
    for (int k = 0; k < ND + 1; k++) run_slot(k % ND, 1'b0, 16'h0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
